// File: rtl/mem_access_stage.sv
// MEM stage of the Mini-RISC-V pipeline: data-memory loads/stores over a req/ack
// handshake, with byte lanes, load extension, upstream stall and the MEM_WB bundle.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        debug,
  input  logic        EX_MEM_valid,
  input  logic [31:0] EX_MEM_alures,
  input  logic [31:0] EX_MEM_storeval,
  input  logic        EX_MEM_memread,
  input  logic        EX_MEM_memwrite,
  input  logic [2:0]  EX_MEM_funct3,
  input  logic        EX_MEM_regwrite,
  input  logic [4:0]  EX_MEM_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        MEM_stall,
  output logic        MEM_fault,
  output logic [31:0] MEM_WB_alures,
  output logic [31:0] MEM_WB_memres,
  output logic        MEM_WB_memread,
  output logic        MEM_WB_regwrite,
  output logic [4:0]  MEM_WB_rd
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state;
  logic [7:0]  tmo_cnt;
  logic        tmo_hit;
  logic [31:0] load_data;

  logic        access, is_load, bad_f3, misaligned, fault, legal;
  logic [3:0]  be_next;
  logic [31:0] wdata_next, ext_data, byte_word;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    bad_f3     = 1'b0;
    misaligned = 1'b0;
    be_next    = 4'b1111;
    wdata_next = 32'h0;
    ext_data   = dmem_rdata;

    // memread wins when both are set
    is_load = EX_MEM_memread;
    access  = EX_MEM_valid & (EX_MEM_memread | EX_MEM_memwrite);

    case (EX_MEM_funct3)
      3'b000:         ;
      3'b001:         misaligned = EX_MEM_alures[0];
      3'b010:         misaligned = |EX_MEM_alures[1:0];
      3'b100, 3'b101: begin
        bad_f3     = !is_load;
        misaligned = EX_MEM_funct3[0] & EX_MEM_alures[0];
      end
      default:        bad_f3 = 1'b1;
    endcase
    fault = access & (bad_f3 | misaligned);
    legal = access & !fault;

    if (!is_load) begin
      case (EX_MEM_funct3[1:0])
        2'b00: begin
          be_next    = 4'b0001 << EX_MEM_alures[1:0];
          wdata_next = {4{EX_MEM_storeval[7:0]}};
        end
        2'b01: begin
          be_next    = 4'b0011 << EX_MEM_alures[1:0];
          wdata_next = {2{EX_MEM_storeval[15:0]}};
        end
        default: wdata_next = EX_MEM_storeval;
      endcase
    end

    byte_word = dmem_rdata >> {EX_MEM_alures[1:0], 3'b000};
    half_sel  = EX_MEM_alures[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (EX_MEM_funct3)
      3'b000:  ext_data = {{24{byte_word[7]}}, byte_word[7:0]};
      3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  ext_data = {24'h0, byte_word[7:0]};
      3'b101:  ext_data = {16'h0, half_sel};
      default: ext_data = dmem_rdata;
    endcase
  end

  always_comb begin
    MEM_stall = 1'b0;
    case (state)
      S_IDLE:  MEM_stall = legal;
      S_WAIT:  MEM_stall = 1'b1;
      S_DONE:  MEM_stall = debug;
      default: MEM_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (Rst) begin
      state           <= S_IDLE;
      tmo_cnt         <= 8'd0;
      tmo_hit         <= 1'b0;
      load_data       <= 32'h0;
      dmem_req        <= 1'b0;
      dmem_we         <= 1'b0;
      dmem_addr       <= 32'h0;
      dmem_be         <= 4'h0;
      dmem_wdata      <= 32'h0;
      MEM_fault       <= 1'b0;
      MEM_WB_alures   <= 32'h0;
      MEM_WB_memres   <= 32'h0;
      MEM_WB_memread  <= 1'b0;
      MEM_WB_regwrite <= 1'b0;
      MEM_WB_rd       <= 5'd0;
    end else begin
      MEM_fault <= 1'b0;
      case (state)
        S_IDLE: if (!debug) begin
          if (legal) begin
            dmem_req        <= 1'b1;
            dmem_we         <= !is_load;
            dmem_addr       <= {EX_MEM_alures[31:2], 2'b00};
            dmem_be         <= be_next;
            dmem_wdata      <= wdata_next;
            MEM_WB_regwrite <= 1'b0;
            tmo_cnt         <= 8'd0;
            tmo_hit         <= 1'b0;
            state           <= S_WAIT;
          end else begin
            MEM_WB_alures   <= EX_MEM_alures;
            MEM_WB_memres   <= 32'h0;
            MEM_WB_memread  <= EX_MEM_memread;
            MEM_WB_regwrite <= EX_MEM_regwrite & !fault;
            MEM_WB_rd       <= EX_MEM_rd;
            MEM_fault       <= fault;
          end
        end
        S_WAIT: begin
          if (dmem_ack) begin
            dmem_req  <= 1'b0;
            load_data <= is_load ? ext_data : 32'h0;
            state     <= S_DONE;
          end else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
            dmem_req  <= 1'b0;
            load_data <= 32'h0;
            tmo_hit   <= 1'b1;
            MEM_fault <= 1'b1;
            state     <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        S_DONE: if (!debug) begin
          MEM_WB_alures   <= EX_MEM_alures;
          MEM_WB_memres   <= load_data;
          MEM_WB_memread  <= EX_MEM_memread;
          MEM_WB_regwrite <= EX_MEM_regwrite & !tmo_hit;
          MEM_WB_rd       <= EX_MEM_rd;
          state           <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed, table-driven bench for mem_access_stage with hand-computed expectations
// and hand-written sequences for timeout, debug freeze and reset during WAIT.
module tb_mem_access_stage;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        Rst;
  logic        debug;
  logic        EX_MEM_valid;
  logic [31:0] EX_MEM_alures;
  logic [31:0] EX_MEM_storeval;
  logic        EX_MEM_memread;
  logic        EX_MEM_memwrite;
  logic [2:0]  EX_MEM_funct3;
  logic        EX_MEM_regwrite;
  logic [4:0]  EX_MEM_rd;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        MEM_stall, MEM_fault;
  logic [31:0] MEM_WB_alures, MEM_WB_memres;
  logic        MEM_WB_memread, MEM_WB_regwrite;
  logic [4:0]  MEM_WB_rd;

  int total = 0;
  int bad   = 0;

  mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .Rst(Rst), .debug(debug),
    .EX_MEM_valid(EX_MEM_valid), .EX_MEM_alures(EX_MEM_alures),
    .EX_MEM_storeval(EX_MEM_storeval), .EX_MEM_memread(EX_MEM_memread),
    .EX_MEM_memwrite(EX_MEM_memwrite), .EX_MEM_funct3(EX_MEM_funct3),
    .EX_MEM_regwrite(EX_MEM_regwrite), .EX_MEM_rd(EX_MEM_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .MEM_stall(MEM_stall), .MEM_fault(MEM_fault),
    .MEM_WB_alures(MEM_WB_alures), .MEM_WB_memres(MEM_WB_memres),
    .MEM_WB_memread(MEM_WB_memread), .MEM_WB_regwrite(MEM_WB_regwrite),
    .MEM_WB_rd(MEM_WB_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, mr, mw;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic        regw;
    logic [4:0]  rd;
    logic        exp_fault, exp_regw, exp_mr;
  } sc_vec_t;

  typedef struct {
    logic        mr, mw;
    logic [2:0]  f3;
    logic [31:0] addr, sv, rdata;
    int          ack_wait;
    logic        regw;
    logic [4:0]  rd;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata, memres;
  } mem_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic mr, input logic mw, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sv, input logic regw,
                        input logic [4:0] rd);
    EX_MEM_valid = v;  EX_MEM_memread = mr; EX_MEM_memwrite = mw;
    EX_MEM_funct3 = f3; EX_MEM_alures = addr; EX_MEM_storeval = sv;
    EX_MEM_regwrite = regw; EX_MEM_rd = rd;
  endtask

  // Drives the memory side until the stage releases the stall (bounded), acking in
  // the ack_wait-th request cycle (0 = never); records the launched request fields.
  task automatic run_access(input int ack_wait, input logic [31:0] word,
                            output int stall_cyc, output int req_cyc,
                            output logic [31:0] a, output logic [3:0] b, output logic w,
                            output logic [31:0] d, output logic stable);
    stall_cyc = 0; req_cyc = 0; a = '0; b = '0; w = 1'b0; d = '0; stable = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (!MEM_stall) break;
      stall_cyc++;
      if (dmem_req) begin
        if (req_cyc == 0) begin
          a = dmem_addr; b = dmem_be; w = dmem_we; d = dmem_wdata;
        end else if (dmem_addr !== a || dmem_be !== b || dmem_we !== w || dmem_wdata !== d) begin
          stable = 1'b0;
        end
        req_cyc++;
        if (req_cyc == ack_wait) begin
          dmem_ack = 1'b1; dmem_rdata = word;
        end
      end
      step();
      dmem_ack = 1'b0; dmem_rdata = 32'h0;
    end
  endtask

  sc_vec_t  sc[9];
  mem_vec_t mv[9];

  initial begin
    int sc_n, rq_n;
    logic [31:0] ra, rd_w;
    logic [3:0]  rb;
    logic        rw, st;

    sc[0] = '{1, 0, 0, 3'b000, 32'h0000_1234, 1, 5'd5,  0, 1, 0};  // ALU op
    sc[1] = '{1, 1, 0, 3'b010, 32'h0000_0041, 1, 5'd6,  1, 0, 1};  // LW misaligned
    sc[2] = '{1, 1, 0, 3'b001, 32'h0000_0011, 1, 5'd7,  1, 0, 1};  // LH misaligned
    sc[3] = '{1, 0, 1, 3'b010, 32'h0000_0002, 0, 5'd0,  1, 0, 0};  // SW misaligned
    sc[4] = '{1, 0, 1, 3'b001, 32'h0000_0007, 0, 5'd0,  1, 0, 0};  // SH misaligned
    sc[5] = '{1, 1, 0, 3'b011, 32'h0000_0000, 1, 5'd8,  1, 0, 1};  // reserved load
    sc[6] = '{1, 0, 1, 3'b100, 32'h0000_0000, 0, 5'd0,  1, 0, 0};  // reserved store
    sc[7] = '{0, 0, 1, 3'b010, 32'h0000_0043, 0, 5'd0,  0, 0, 0};  // bubble
    sc[8] = '{1, 0, 0, 3'b000, 32'hDEAD_BEEF, 1, 5'd31, 0, 1, 0};  // ALU op

    mv[0] = '{1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 2, 1, 5'd7,  4'b1111, 0, 32'h0, 32'hFFFF_FF80};
    mv[1] = '{1, 0, 3'b001, 32'h006, 32'h0, 32'h8001_1234, 1, 1, 5'd8,  4'b1111, 0, 32'h0, 32'hFFFF_8001};
    mv[2] = '{1, 0, 3'b100, 32'h001, 32'h0, 32'h0000_F200, 3, 1, 5'd9,  4'b1111, 0, 32'h0, 32'h0000_00F2};
    mv[3] = '{1, 0, 3'b101, 32'h002, 32'h0, 32'hABCD_0000, 1, 1, 5'd10, 4'b1111, 0, 32'h0, 32'h0000_ABCD};
    mv[4] = '{1, 0, 3'b010, 32'h010, 32'h0, 32'h89AB_CDEF, 1, 1, 5'd11, 4'b1111, 0, 32'h0, 32'h89AB_CDEF};
    mv[5] = '{0, 1, 3'b001, 32'h022, 32'hABCD_5678, 32'h0, 1, 0, 5'd0, 4'b1100, 1, 32'h5678_5678, 32'h0};
    mv[6] = '{0, 1, 3'b000, 32'h031, 32'h0000_00A5, 32'h0, 2, 0, 5'd0, 4'b0010, 1, 32'hA5A5_A5A5, 32'h0};
    mv[7] = '{0, 1, 3'b010, 32'h03C, 32'hCAFE_F00D, 32'h0, 1, 0, 5'd0, 4'b1111, 1, 32'hCAFE_F00D, 32'h0};
    mv[8] = '{1, 1, 3'b100, 32'h005, 32'h1111_2222, 32'h0000_9900, 1, 1, 5'd12, 4'b1111, 0, 32'h0, 32'h0000_0099};

    Rst = 1'b1; debug = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    set_ex(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 5'd0);
    step(); step();
    check("rst_req", dmem_req, 0);
    check("rst_fault", MEM_fault, 0);
    check("rst_stall", MEM_stall, 0);
    check("rst_wb_alures", MEM_WB_alures, 0);
    check("rst_wb_regwrite", MEM_WB_regwrite, 0);
    Rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      set_ex(sc[i].valid, sc[i].mr, sc[i].mw, sc[i].f3, sc[i].addr, 32'h5555_AAAA, sc[i].regw, sc[i].rd);
      #1;
      check($sformatf("sc%0d_stall", i), MEM_stall, 0);
      step();
      check($sformatf("sc%0d_req", i), dmem_req, 0);
      check($sformatf("sc%0d_fault", i), MEM_fault, sc[i].exp_fault);
      check($sformatf("sc%0d_alures", i), MEM_WB_alures, sc[i].addr);
      check($sformatf("sc%0d_regwrite", i), MEM_WB_regwrite, sc[i].exp_regw);
      check($sformatf("sc%0d_memread", i), MEM_WB_memread, sc[i].exp_mr);
      check($sformatf("sc%0d_rd", i), MEM_WB_rd, sc[i].rd);
      check($sformatf("sc%0d_memres", i), MEM_WB_memres, 0);
    end

    for (int i = 0; i < 9; i++) begin
      set_ex(1, mv[i].mr, mv[i].mw, mv[i].f3, mv[i].addr, mv[i].sv, mv[i].regw, mv[i].rd);
      #1;
      run_access(mv[i].ack_wait, mv[i].rdata, sc_n, rq_n, ra, rb, rw, rd_w, st);
      check($sformatf("mv%0d_stall_cycles", i), sc_n, mv[i].ack_wait + 1);
      check($sformatf("mv%0d_req_cycles", i), rq_n, mv[i].ack_wait);
      check($sformatf("mv%0d_addr", i), ra, {mv[i].addr[31:2], 2'b00});
      check($sformatf("mv%0d_be", i), rb, mv[i].be);
      check($sformatf("mv%0d_we", i), rw, mv[i].we);
      check($sformatf("mv%0d_wdata", i), rd_w, mv[i].wdata);
      check($sformatf("mv%0d_stable", i), st, 1);
      check($sformatf("mv%0d_done_req", i), dmem_req, 0);
      check($sformatf("mv%0d_done_fault", i), MEM_fault, 0);
      check($sformatf("mv%0d_bubble", i), MEM_WB_regwrite, 0);
      step();
      check($sformatf("mv%0d_memres", i), MEM_WB_memres, mv[i].memres);
      check($sformatf("mv%0d_regwrite", i), MEM_WB_regwrite, mv[i].regw);
      check($sformatf("mv%0d_memread", i), MEM_WB_memread, mv[i].mr);
      check($sformatf("mv%0d_rd", i), MEM_WB_rd, mv[i].rd);
      check($sformatf("mv%0d_alures", i), MEM_WB_alures, mv[i].addr);
    end

    // LHU that is never acknowledged
    set_ex(1, 1, 0, 3'b101, 32'h52, 32'h0, 1, 5'd14);
    #1;
    run_access(0, 32'h0, sc_n, rq_n, ra, rb, rw, rd_w, st);
    check("tmo_req_cycles", rq_n, TIMEOUT);
    check("tmo_stall_cycles", sc_n, TIMEOUT + 1);
    check("tmo_addr", ra, 32'h50);
    check("tmo_fault", MEM_fault, 1);
    check("tmo_req_dropped", dmem_req, 0);
    step();
    check("tmo_fault_pulse", MEM_fault, 0);
    check("tmo_regwrite", MEM_WB_regwrite, 0);
    check("tmo_memres", MEM_WB_memres, 0);
    set_ex(1, 0, 0, 3'b000, 32'h77, 32'h0, 1, 5'd3);
    #1;
    check("tmo_resume_stall", MEM_stall, 0);
    step();
    check("tmo_resume_regwrite", MEM_WB_regwrite, 1);
    check("tmo_resume_rd", MEM_WB_rd, 3);

    // debug freeze in IDLE and in DONE
    debug = 1'b1;
    set_ex(1, 1, 0, 3'b010, 32'h40, 32'h0, 1, 5'd12);
    step(); step();
    check("dbg_idle_req", dmem_req, 0);
    check("dbg_idle_rd", MEM_WB_rd, 3);
    check("dbg_idle_alures", MEM_WB_alures, 32'h77);
    debug = 1'b0;
    #1;
    run_access(1, 32'h1122_3344, sc_n, rq_n, ra, rb, rw, rd_w, st);
    check("dbg_stall_cycles", sc_n, 2);
    debug = 1'b1;
    #1;
    check("dbg_done_stall", MEM_stall, 1);
    step();
    check("dbg_done_hold_stall", MEM_stall, 1);
    check("dbg_done_hold_rd", MEM_WB_rd, 3);
    debug = 1'b0;
    #1;
    check("dbg_done_release", MEM_stall, 0);
    step();
    check("dbg_memres", MEM_WB_memres, 32'h1122_3344);
    check("dbg_rd", MEM_WB_rd, 12);

    // reset while waiting for an ack; the late ack must be ignored
    set_ex(1, 1, 0, 3'b010, 32'h80, 32'h0, 1, 5'd13);
    step();
    check("rstw_launch_req", dmem_req, 1);
    step();
    Rst = 1'b1;
    set_ex(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 5'd0);
    step();
    check("rstw_req", dmem_req, 0);
    check("rstw_stall", MEM_stall, 0);
    check("rstw_wb_alures", MEM_WB_alures, 0);
    check("rstw_wb_memres", MEM_WB_memres, 0);
    check("rstw_wb_flags", {MEM_WB_memread, MEM_WB_regwrite, MEM_WB_rd}, 0);
    Rst = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    step();
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    step();
    check("rstw_late_req", dmem_req, 0);
    check("rstw_late_stall", MEM_stall, 0);
    check("rstw_late_memres", MEM_WB_memres, 0);
    check("rstw_late_regwrite", MEM_WB_regwrite, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
